// File: rtl/clock_divider_mc.sv
// Multi-channel programmable clock divider with phase preload
// and per-channel glitch-free shadow reload on period wrap.
module clock_divider_mc #(
  parameter int NCH = 2,
  parameter int W   = 28
) (
  input  logic             clock_in,
  input  logic             reset_n,
  input  logic             enable,
  input  logic             load,
  input  logic [NCH*W-1:0] divisor_in,
  input  logic [NCH*W-1:0] high_in,
  input  logic [NCH*W-1:0] phase_in,
  output logic [NCH-1:0]   clock_out,
  output logic [NCH-1:0]   period_tick,
  output logic             load_pending
);

  typedef enum logic {IDLE, RUN} state_t;

  localparam logic [W-1:0] ONE = W'(1);

  state_t state;

  logic [W-1:0] cnt     [NCH];
  logic [W-1:0] div_a   [NCH];
  logic [W-1:0] high_a  [NCH];
  logic [W-1:0] phase_a [NCH];
  logic [W-1:0] div_s   [NCH];
  logic [W-1:0] high_s  [NCH];
  logic [W-1:0] phase_s [NCH];
  logic [W-1:0] div_n   [NCH];
  logic [W-1:0] high_n  [NCH];
  logic [W-1:0] phase_n [NCH];
  logic [W-1:0] start   [NCH];

  logic [NCH-1:0] armed;
  logic [NCH-1:0] nz;
  logic [NCH-1:0] last;
  logic [NCH-1:0] wrap;
  logic [NCH-1:0] apply;

  assign load_pending = |armed;

  // Guarding with nz keeps div_a-1 from ever underflowing.
  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      nz[i]    = div_a[i] != '0;
      last[i]  = nz[i] && (cnt[i] == div_a[i] - ONE);
      wrap[i]  = nz[i] && (cnt[i] >= div_a[i] - ONE);
      apply[i] = armed[i] && enable && (!nz[i] || wrap[i]);
      div_n[i] = load     ? divisor_in[i*W +: W] :
                 armed[i] ? div_s[i] : div_a[i];
      high_n[i] = load     ? high_in[i*W +: W] :
                  armed[i] ? high_s[i] : high_a[i];
      phase_n[i] = load     ? phase_in[i*W +: W] :
                   armed[i] ? phase_s[i] : phase_a[i];
      start[i] = (phase_n[i] < div_n[i]) ? phase_n[i] : '0;
    end
  end

  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      armed       <= '0;
      clock_out   <= '0;
      period_tick <= '0;
      for (int i = 0; i < NCH; i++) begin
        cnt[i]     <= '0;
        div_a[i]   <= '0;
        high_a[i]  <= '0;
        phase_a[i] <= '0;
        div_s[i]   <= '0;
        high_s[i]  <= '0;
        phase_s[i] <= '0;
      end
    end else begin
      unique case (state)
        IDLE: begin
          clock_out   <= '0;
          period_tick <= '0;
          armed       <= '0;
          for (int i = 0; i < NCH; i++) begin
            div_a[i]   <= div_n[i];
            high_a[i]  <= high_n[i];
            phase_a[i] <= phase_n[i];
            cnt[i]     <= enable ? start[i] : '0;
          end
          if (enable) state <= RUN;
        end
        RUN: begin
          // A new capture re-arms every channel, even ones already updated.
          armed <= load ? '1 : (armed & ~apply);
          for (int i = 0; i < NCH; i++) begin
            if (load) begin
              div_s[i]   <= divisor_in[i*W +: W];
              high_s[i]  <= high_in[i*W +: W];
              phase_s[i] <= phase_in[i*W +: W];
            end
            if (apply[i]) begin
              div_a[i]   <= div_s[i];
              high_a[i]  <= high_s[i];
              phase_a[i] <= phase_s[i];
            end
            if (!enable || !nz[i]) begin
              cnt[i]         <= '0;
              clock_out[i]   <= 1'b0;
              period_tick[i] <= 1'b0;
            end else begin
              cnt[i]         <= wrap[i] ? '0 : cnt[i] + ONE;
              clock_out[i]   <= cnt[i] < high_a[i];
              period_tick[i] <= last[i];
            end
          end
          if (!enable) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_clock_divider_mc.sv
// Directed self-checking bench for clock_divider_mc.
// Observed word is {load_pending, period_tick[1:0], clock_out[1:0]}.
module tb_clock_divider_mc;

  localparam int NCH = 2;
  localparam int W   = 28;

  logic             clock_in = 1'b0;
  logic             reset_n  = 1'b0;
  logic             enable   = 1'b0;
  logic             load     = 1'b0;
  logic [NCH*W-1:0] divisor_in = '0;
  logic [NCH*W-1:0] high_in    = '0;
  logic [NCH*W-1:0] phase_in   = '0;
  logic [NCH-1:0]   clock_out;
  logic [NCH-1:0]   period_tick;
  logic             load_pending;

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [4:0] TAB_R [13] = '{
    5'b0_00_11, 5'b0_00_11, 5'b0_00_11, 5'b1_00_01,
    5'b1_00_00, 5'b1_10_00, 5'b1_00_10, 5'b0_01_00,
    5'b0_10_01, 5'b0_00_10, 5'b0_00_00, 5'b0_11_00,
    5'b0_00_11};

  localparam logic [4:0] TAB_D [15] = '{
    5'b0_00_01, 5'b0_00_01, 5'b1_00_01, 5'b1_00_01,
    5'b1_00_10, 5'b1_10_00, 5'b1_00_10, 5'b0_01_10,
    5'b0_10_01, 5'b0_00_11, 5'b0_00_10, 5'b0_10_00,
    5'b0_00_10, 5'b0_01_10, 5'b0_10_01};

  always #5 clock_in = ~clock_in;

  clock_divider_mc #(.NCH(NCH), .W(W)) dut (
    .clock_in     (clock_in),
    .reset_n      (reset_n),
    .enable       (enable),
    .load         (load),
    .divisor_in   (divisor_in),
    .high_in      (high_in),
    .phase_in     (phase_in),
    .clock_out    (clock_out),
    .period_tick  (period_tick),
    .load_pending (load_pending)
  );

  task automatic step();
    @(posedge clock_in);
    #1;
  endtask

  task automatic check(input string tag, input logic [4:0] exp);
    logic [4:0] obs;
    obs = {load_pending, period_tick, clock_out};
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic set_ch(input int ch, input int dv, input int hi, input int ph);
    divisor_in[ch*W +: W] = W'(dv);
    high_in[ch*W +: W]    = W'(hi);
    phase_in[ch*W +: W]   = W'(ph);
  endtask

  task automatic load_idle();
    load = 1'b1;
    step();
    load = 1'b0;
  endtask

  initial begin
    bit c0, c1, t0, t1;

    step();
    step();
    check("reset_hold", 5'b0);
    reset_n = 1'b1;
    step();
    check("reset_release", 5'b0);

    // Basic division 4 / 2
    set_ch(0, 4, 2, 0);
    set_ch(1, 0, 0, 0);
    load_idle();
    check("idle_load", 5'b0);
    enable = 1'b1;
    step();
    check("basic_entry", 5'b0);
    for (int k = 1; k <= 8; k++) begin
      step();
      c0 = ((k - 1) % 4) < 2;
      t0 = ((k - 1) % 4) == 3;
      check($sformatf("basic k%0d", k), {1'b0, 1'b0, t0, 1'b0, c0});
    end
    enable = 1'b0;
    step();
    check("basic_off", 5'b0);

    // Phase offset of 5 on ch1
    set_ch(0, 10, 3, 0);
    set_ch(1, 10, 3, 5);
    load_idle();
    enable = 1'b1;
    step();
    for (int k = 1; k <= 21; k++) begin
      step();
      c0 = ((k - 1) % 10) < 3;
      c1 = ((k + 4) % 10) < 3;
      t0 = ((k - 1) % 10) == 9;
      t1 = ((k + 4) % 10) == 9;
      check($sformatf("phase5 k%0d", k), {1'b0, t1, t0, c1, c0});
    end
    enable = 1'b0;
    step();
    check("drop_mid_period", 5'b0);

    // Phase beyond divisor falls back to 0
    set_ch(1, 10, 3, 12);
    load_idle();
    enable = 1'b1;
    step();
    for (int k = 1; k <= 10; k++) begin
      step();
      c0 = ((k - 1) % 10) < 3;
      t0 = ((k - 1) % 10) == 9;
      check($sformatf("phase12 k%0d", k), {1'b0, t0, t0, c0, c0});
    end
    enable = 1'b0;
    step();

    // Load coincident with enable rise
    set_ch(1, 10, 3, 7);
    load   = 1'b1;
    enable = 1'b1;
    step();
    load = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      step();
      c0 = ((k - 1) % 10) < 3;
      c1 = ((k + 6) % 10) < 3;
      t0 = ((k - 1) % 10) == 9;
      t1 = ((k + 6) % 10) == 9;
      check($sformatf("coinc k%0d", k), {1'b0, t1, t0, c1, c0});
    end
    enable = 1'b0;
    step();

    // Glitch-free reload mid-period
    set_ch(0, 8, 4, 0);
    set_ch(1, 6, 3, 0);
    load_idle();
    enable = 1'b1;
    step();
    for (int k = 1; k <= 13; k++) begin
      if (k == 4) begin
        set_ch(0, 4, 1, 0);
        set_ch(1, 3, 1, 0);
        load = 1'b1;
      end
      step();
      load = 1'b0;
      check($sformatf("reload k%0d", k), TAB_R[k-1]);
    end
    enable = 1'b0;
    step();

    // Double load before ch0 wraps
    set_ch(0, 8, 4, 0);
    set_ch(1, 0, 0, 0);
    load_idle();
    enable = 1'b1;
    step();
    for (int k = 1; k <= 15; k++) begin
      if (k == 3) begin
        set_ch(0, 4, 1, 0);
        set_ch(1, 2, 1, 0);
        load = 1'b1;
      end
      if (k == 5) begin
        set_ch(0, 6, 2, 0);
        set_ch(1, 3, 2, 0);
        load = 1'b1;
      end
      step();
      load = 1'b0;
      check($sformatf("dblload k%0d", k), TAB_D[k-1]);
    end
    enable = 1'b0;
    step();

    // div=1 high=1 on ch0, div=0 on ch1
    set_ch(0, 1, 1, 0);
    set_ch(1, 0, 5, 0);
    load_idle();
    enable = 1'b1;
    step();
    for (int k = 1; k <= 4; k++) begin
      step();
      check($sformatf("div1 k%0d", k), 5'b0_01_01);
    end
    enable = 1'b0;
    step();
    check("div1_off", 5'b0);

    // high=0 gives 0, high=div gives 1
    set_ch(0, 5, 0, 0);
    set_ch(1, 5, 5, 0);
    load_idle();
    enable = 1'b1;
    step();
    for (int k = 1; k <= 10; k++) begin
      step();
      t0 = ((k - 1) % 5) == 4;
      check($sformatf("duty k%0d", k), {1'b0, t0, t0, 2'b10});
    end
    enable = 1'b0;
    step();

    // Async reset while running with a pending load
    set_ch(0, 8, 4, 0);
    set_ch(1, 8, 4, 0);
    load_idle();
    enable = 1'b1;
    step();
    step();
    step();
    step();
    set_ch(0, 3, 1, 0);
    set_ch(1, 3, 1, 0);
    load = 1'b1;
    step();
    load = 1'b0;
    check("pre_reset", 5'b1_00_11);
    #2 reset_n = 1'b0;
    #1 check("async_reset", 5'b0);
    #1 reset_n = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      step();
      check($sformatf("post_reset k%0d", k), 5'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/clock_divider_mc.md
CLOCK_DIVIDER_MC -- requirements
Module: clock_divider_mc

Interface
REQ-001 Parameter NCH, default 2, number of independent divider channels.
REQ-002 Parameter W, default 28, width of every counter and configuration field.
REQ-003 clock_in  input  1  single clock for all logic.
REQ-004 reset_n  input  1  reset, asynchronous assert, active-low.
REQ-005 enable  input  1  level; 1 = run all channels, 0 = idle.
REQ-006 load  input  1  one-cycle strobe capturing divisor_in, high_in, phase_in.
REQ-007 divisor_in  input  NCH*W  per-channel period in clock_in cycles; channel i uses bits [i*W +: W].
REQ-008 high_in  input  NCH*W  per-channel high time in cycles.
REQ-009 phase_in  input  NCH*W  per-channel start count applied on entry to RUN.
REQ-010 clock_out  output  NCH  registered divided clocks.
REQ-011 period_tick  output  NCH  one-cycle pulse per channel at period wrap.
REQ-012 load_pending  output  1  high while captured configuration awaits application in RUN.

Function
REQ-013 The block SHALL have two states: IDLE and RUN.
REQ-014 IDLE->RUN SHALL occur on the first clock with enable=1; RUN->IDLE SHALL occur on the first clock with enable=0.
REQ-015 In IDLE, all counters SHALL be 0, and clock_out and period_tick SHALL be 0 from the cycle after entry.
REQ-016 load in IDLE SHALL write inputs directly into the active registers (div_a, high_a, phase_a) on that edge; load_pending stays 0.
REQ-017 On the IDLE->RUN edge, counter[i] SHALL load phase_a[i] if phase_a[i] < div_a[i], else 0.
REQ-018 If load and the IDLE->RUN transition coincide, the newly loaded values SHALL be used for the phase preload.
REQ-019 In RUN, counter[i] SHALL increment by 1 per cycle and wrap to 0 when counter[i] >= div_a[i]-1.
REQ-020 clock_out[i] SHALL equal, one cycle later, (counter[i] < high_a[i]), giving one-cycle registered latency.
REQ-021 period_tick[i] SHALL equal, one cycle later, (counter[i] == div_a[i]-1).
REQ-022 Consequently, high_a >= div_a SHALL give a constant 1, and high_a = 0 SHALL give a constant 0.
REQ-023 div_a[i] = 0 SHALL disable channel i: counter held at 0, clock_out[i]=0, period_tick[i]=0.
REQ-024 div_a[i] = 1 SHALL hold counter[i] at 0, with period_tick[i]=1 every RUN cycle and clock_out[i]=(high_a[i]>=1).
REQ-025 load in RUN SHALL capture inputs into shadow registers and set load_pending=1 on the next cycle.
REQ-026 Each channel SHALL copy its shadow into active on its own wrap cycle, so no period is truncated or stretched (glitch-free).
REQ-027 A disabled channel (div_a=0) SHALL apply its shadow on the first cycle after capture.
REQ-028 load_pending SHALL clear on the cycle after the last channel applies its shadow.
REQ-029 A second load while load_pending=1 SHALL overwrite the shadows, and channels not yet updated SHALL take the newer values.
REQ-030 Channels already updated SHALL be re-armed, so that load_pending clears only after every channel has applied the newest capture.
REQ-031 Phase SHALL be applied only on entry to RUN, never on a shadow update.
REQ-032 All comparisons SHALL be unsigned W-bit, and div_a-1 SHALL not be evaluated when div_a=0.

Reset
REQ-033 While reset_n=0: state=IDLE, counters=0, active and shadow registers=0, clock_out=0, period_tick=0, load_pending=0.
REQ-034 Reset asserted mid-RUN or mid-pending SHALL discard all configuration, which requires a new load after release.
REQ-035 The first edge after reset_n rises SHALL behave as a normal IDLE cycle.

Verification
REQ-036 Basic division: ch0 div=4, high=2, phase=0, loaded in IDLE, then enable=1 -> clock_out[0] pattern 1,1,0,0 repeating starting 2 cycles after the enable edge; period_tick[0] on every 4th cycle.
REQ-037 Phase and duty: ch0 div=10, high=3, phase=0; ch1 div=10, high=3, phase=5 -> ch1 waveform leads ch0 by 5 cycles; phase=12 on ch1 -> treated as 0, so ch1 aligns with ch0.
REQ-038 Glitch-free reload: ch0 div=8, high=4 running; load div=4, high=1 mid-period -> old period completes fully, then the new pattern starts; load_pending stays high until both channels have wrapped.
REQ-039 Edges: div=0 -> output 0 and no ticks; div=1, high=1 -> constant 1 with a tick every cycle; high=0 -> constant 0; high=div -> constant 1.
REQ-040 Simultaneous events: load coincident with the enable rise uses the new phase; a double load before a wrap takes the second value; enable dropped mid-period -> outputs 0 after one cycle.
REQ-041 Asynchronous reset: reset_n pulsed low between clock edges while RUN and load_pending=1 -> all outputs 0 immediately; after release with enable=1 and no load, all channels stay disabled.
